csa_seq_mult: RTL and testbench
===============================

# csa_seq_mult

Iterative unsigned multiplier that sequences a single carry-save adder row over W cycles. Each cycle it folds one partial product into a redundant (sum, carry) accumulator. One final carry-propagate cycle then resolves the product. It sits in the ALU as the low-area multiply unit behind a valid/ready request port, sharing issue slots with the other ALU pipes.

## Interface

Parameters:
- `WIDTH`, default 16: operand width W, must be ≥ 2; the product is 2W bits.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high (already decided); one clock, no other clock domains.
- `in_valid`, input, 1: operand pair present.
- `in_ready`, output, 1: block can accept an operand pair.
- `in_a`, input, W: multiplicand, unsigned.
- `in_b`, input, W: multiplier, unsigned.
- `out_valid`, output, 1: product valid.
- `out_ready`, input, 1: consumer accepts the product.
- `out_prod`, output, 2W: registered product a·b.
- `busy`, output, 1: high in every state except IDLE.

## Operation

- FSM states, encoded in the package enum: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: load `a_reg` = zero-extend(`in_a`) to 2W, load `b_reg` = `in_b`, clear `sum_reg`/`carry_reg`, set `cnt` = 0, go to ACCUM.
- ACCUM, one step per cycle:
  - `pp` = `b_reg[0]` ? `a_reg` : 0.
  - CSA row computes s = sum⊕carry⊕pp and c = maj(sum, carry, pp).
  - `sum_reg` ← s; `carry_reg` ← c << 1, truncated to 2W; bits shifted past 2W are dropped (result is exact mod 2^2W).
  - `a_reg` ← `a_reg` << 1; `b_reg` ← `b_reg` >> 1; `cnt` ← `cnt` + 1.
  - Exit to RESOLVE on the step where `cnt` == W−1. Early exit is covered under Configuration.
- RESOLVE:
  - `out_prod` ← `sum_reg` + `carry_reg` (2W-bit add, carry-out discarded).
  - `out_valid` ← 1; go to DONE.
- DONE:
  - `out_valid` held at 1; `out_prod` held stable.
  - On `out_ready`: `out_valid` ← 0, go to IDLE.
- `in_ready` = 0 in ACCUM, RESOLVE and DONE. There is no operation overlap, and a new request is never accepted in the same cycle a product is consumed.
- `cnt` width is $clog2(W).
- `in_a`/`in_b` are sampled only on the accepting edge; later changes are ignored.

## Timing

- Reset values, applied on any edge with `rst` = 1:
  - State IDLE.
  - `out_valid` = 0, `out_prod` = 0, `busy` = 0.
  - All datapath registers 0.
  - `in_ready` = 1, combinational from state.
- Reset mid-operation, in any state: the operation is abandoned, no product is emitted, and the block is in IDLE on the next cycle. Reset overrides a simultaneous accept or consume.
- Latency, with the accepting edge as T0:
  - ACCUM steps occur on edges T1..TW.
  - RESOLVE occurs on edge TW+1.
  - `out_valid` is high after TW+1, i.e. W+1 clocks after accept.
- Minimum issue interval, with `out_ready` tied high: W+3 clocks.
- `out_valid` never drops without `out_ready`. `out_prod` changes only on the RESOLVE edge or on reset.

## Configuration

- Macro `CSA_SEQ_MULT_EARLY_TERM_EN`.
- Defined:
  - ACCUM also exits to RESOLVE when (`b_reg` >> 1) == 0 during the current step.
  - Effective latency = (index of MSB set in `in_b`) + 2 clocks after accept.
  - If `in_b` = 0, exactly one ACCUM cycle is performed.
- Undefined: ACCUM always runs exactly W cycles; latency is fixed at W+1.
- The product value is identical in both builds.

## Structure

- Package `csa_mult_pkg`:
  - `csa_mult_state_e` state enum.
  - `CSA_MULT_DEF_WIDTH` = 16.
- Sub-module `csa_row`:
  - Parameter N; inputs x, y, z, each N bits; outputs s and c, each N bits.
  - A bitwise array of 3:2 compressors, purely combinational.
  - Instantiated once with N = 2W.
- The carry-propagate add in RESOLVE is inline; no sub-module is used for it.

## Test plan

All scenarios use W = 8.
- Corner product: a=0xFF, b=0xFF, accept at T0 → `out_valid` after T9, `out_prod`=0xFE01; without the macro, exactly 8 cycles with `busy` high in ACCUM.
- Zero and early termination: a=0x00, b=0x5A → 0x0000. With the macro defined: a=0x03, b=0x05 → 0x000F, `out_valid` after T4.
- Backpressure: `out_ready` low for 5 cycles after `out_valid` → `out_prod` stable, `in_ready`=0, and `in_valid` pulses during DONE are not accepted.
- Reset mid-op: assert `rst` for one cycle on T4 of a 0xAB×0xCD operation → `out_valid` never rises, IDLE/`in_ready`=1 on the next cycle; a following 0x12×0x34 gives 0x03A8.
- Back-to-back with `out_ready`=1 and `in_valid` held high: accepts spaced 11 clocks apart; 1000 random pairs are checked against a·b.

Source files
------------

// File: rtl/csa_mult_pkg.sv
// Shared types and defaults for the carry-save sequential multiplier.
// Holds the FSM state enum and the default operand width.
package csa_mult_pkg;

  localparam int CSA_MULT_DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } csa_mult_state_e;

endpackage

// File: rtl/csa_seq_mult_row.sv
// One carry-save adder row: a bitwise array of 3:2 compressors.
// Purely combinational; the caller applies the carry shift.
module csa_row #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_seq_mult.sv
// Iterative unsigned multiplier folding one partial product per cycle.
// Optional early termination via macro CSA_SEQ_MULT_EARLY_TERM_EN.
module csa_seq_mult
  import csa_mult_pkg::*;
#(
  parameter int WIDTH = CSA_MULT_DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int P  = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  csa_mult_state_e r_state;
  csa_mult_state_e w_next;

  logic [P-1:0]     r_a;
  logic [WIDTH-1:0] r_b;
  logic [P-1:0]     r_sum;
  logic [P-1:0]     r_carry;
  logic [CW-1:0]    r_cnt;
  logic [P-1:0]     r_prod;
  logic             r_valid;

  logic [P-1:0] w_pp;
  logic [P-1:0] w_s;
  logic [P-1:0] w_c;
  logic         w_last;

  assign w_pp = r_b[0] ? r_a : '0;

  csa_row #(
    .N (P)
  ) u_row (
    .x (r_sum),
    .y (r_carry),
    .z (w_pp),
    .s (w_s),
    .c (w_c)
  );

`ifdef CSA_SEQ_MULT_EARLY_TERM_EN
  // Stop once no multiplier bits remain beyond the current one.
  assign w_last = (r_cnt == LAST) ||
                  (r_b[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == LAST);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = RESOLVE;
      RESOLVE: w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= {{WIDTH{1'b0}}, in_a};
            r_b     <= in_b;
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
          end
        end
        ACCUM: begin
          r_sum   <= w_s;
          r_carry <= {w_c[P-2:0], 1'b0};
          r_a     <= {r_a[P-2:0], 1'b0};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
        end
        RESOLVE: begin
          r_prod  <= r_sum + r_carry;
          r_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_valid;
  assign out_prod  = r_prod;

endmodule

// File: tb/tb_csa_seq_mult.sv
// Bench for csa_seq_mult at WIDTH=8 against an arithmetic model.
// Expected latency follows CSA_SEQ_MULT_EARLY_TERM_EN when defined.
module tb_csa_seq_mult;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2*W-1:0] out_prod;
  logic         busy;

  int n_checks = 0;
  int n_fail = 0;
  longint cyc = 0;

  csa_seq_mult #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clocks from accept to out_valid, from the multiplier value alone.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef CSA_SEQ_MULT_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < W; i++)
      if (b[i]) msb = i;
    return msb + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      chk("busy_in_flight", {63'd0, busy}, 64'd1);
      step();
      lat++;
    end
    if (lat >= 40) chk("valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic run(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     output logic [2*W-1:0] p);
    int lat;
    logic [2*W-1:0] e;
    e = (2*W)'(a) * (2*W)'(b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("latency", 64'(lat), 64'(exp_lat(b)));
    chk("product", 64'(out_prod), 64'(e));
    p = out_prod;
    step();
    chk("consumed_valid", {63'd0, out_valid}, 64'd0);
    chk("consumed_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [2*W-1:0] e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] pb;
    int lat;
    int k;
    bit seen;
    longint acc;
    longint prev_acc;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_prod", 64'(out_prod), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    step();

    // Corner and zero products
    run(8'hFF, 8'hFF, p);
    chk("corner_const", 64'(p), 64'h0000_FE01);
    run(8'h00, 8'h5A, p);
    chk("zero_const", 64'(p), 64'd0);
    run(8'h03, 8'h05, p);
    chk("small_const", 64'(p), 64'h0F);
    run(8'h9C, 8'h00, p);
    run(8'h01, 8'h80, p);

    // Backpressure: hold out_ready low while poking in_valid
    out_ready = 1'b0;
    e = 16'(8'h5A) * 16'(8'h77);
    in_a = 8'h5A;
    in_b = 8'h77;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_product", 64'(out_prod), 64'(e));
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      step();
      chk("bp_prod_stable", 64'(out_prod), 64'(e));
      chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_released_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_not_accepted", {63'd0, busy}, 64'd0);

    // Reset in the middle of an operation
    in_a = 8'hAB;
    in_b = 8'hCD;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_prod", 64'(out_prod), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      step();
    end
    chk("midrst_no_valid", {63'd0, seen}, 64'd0);
    run(8'h12, 8'h34, p);
    chk("post_rst_const", 64'(p), 64'h03A8);

    // Back-to-back random pairs with in_valid held high
    out_ready = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    prev_acc = 0;
    pb = '0;
    for (int i = 0; i < 1000; i++) begin
      k = 0;
      while (in_ready !== 1'b1 && k < 40) begin
        step();
        k++;
      end
      if (k >= 40) chk("b2b_ready_timeout", {63'd0, in_ready}, 64'd1);
      e = (2*W)'(a) * (2*W)'(b);
      step();
      acc = cyc;
      if (i > 0)
        chk("b2b_spacing", 64'(acc - prev_acc),
            64'(exp_lat(pb) + 2));
      prev_acc = acc;
      pb = b;
      a = 8'($urandom);
      b = 8'($urandom);
      in_a = a;
      in_b = b;
      wait_valid(lat);
      chk("b2b_product", 64'(out_prod), 64'(e));
    end
    in_valid = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
